// File: rtl/fft_pkg.sv
// Shared constants and types for the 4-bank radix-2 FFT stage controller.
package fft_pkg;

  localparam int NUMSTAGES = 8;
  localparam int CW        = NUMSTAGES - 2;
  localparam int DEPTH     = 1 << CW;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  typedef enum logic [1:0] {
    ROUTE_STRAIGHT = 2'd0,
    ROUTE_CROSS    = 2'd1,
    ROUTE_SWAP     = 2'd2
  } route_e;

  typedef struct packed {
    logic [CW-1:0] a01;
    logic [CW-1:0] a23;
  } addr_pair_t;

  // The last two stages pair data inside one bank word group, so the PE inputs are rerouted.
  function automatic route_e route_for(input logic [2:0] stage);
    if (int'(stage) == NUMSTAGES - 2)      return ROUTE_CROSS;
    else if (int'(stage) == NUMSTAGES - 1) return ROUTE_SWAP;
    else                                   return ROUTE_STRAIGHT;
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Stage-dependent butterfly partner address and final write-address mapping.
// FFT_CTRL_BITREV_EN: bit-reverse write addresses in the last stage (natural-order output).
module fft_addr_gen
  import fft_pkg::*;
(
  input  logic [2:0]    stage,
  input  logic [CW-1:0] cnt,
  input  logic [CW-1:0] raw_0_1,
  input  logic [CW-1:0] raw_2_3,
  output logic [CW-1:0] partner,
  output logic [CW-1:0] w_0_1,
  output logic [CW-1:0] w_2_3
);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    partner = cnt;
    if (int'(stage) < NUMSTAGES - 2)
      partner = cnt ^ (CW'(1) << (NUMSTAGES - 3 - int'(stage)));
  end

`ifdef FFT_CTRL_BITREV_EN
  function automatic logic [CW-1:0] bitrev(input logic [CW-1:0] a);
    logic [CW-1:0] r;
    r = '0;
    for (int i = 0; i < CW; i++) r[i] = a[CW-1-i];
    return r;
  endfunction

  always_comb begin
    w_0_1 = raw_0_1;
    if (int'(stage) == NUMSTAGES - 1) w_0_1 = bitrev(raw_0_1);
  end

  always_comb begin
    w_2_3 = raw_2_3;
    if (int'(stage) == NUMSTAGES - 1) w_2_3 = bitrev(raw_2_3);
  end
`else
  assign w_0_1 = raw_0_1;
  assign w_2_3 = raw_2_3;
`endif

endmodule

// File: rtl/fft_stage_ctrl.sv
// Per-stage controller: FSM, address counter, PE_LAT write-address delay pipe, registered outputs.
// FFT_CTRL_BITREV_EN selects natural-order output addressing in the last stage.
module fft_stage_ctrl
  import fft_pkg::*;
#(
  parameter int ADDRSIZE = 8,
  parameter int PE_LAT   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ld_data,
  input  logic                en,
  input  logic [2:0]          stage_num,
  output logic                m0_s,
  output logic [1:0]          m1_s,
  output logic                m2_s,
  output logic                m3_s,
  output logic [ADDRSIZE-1:0] r_addr_0_1,
  output logic [ADDRSIZE-1:0] w_addr_0_1,
  output logic [ADDRSIZE-1:0] r_addr_2_3,
  output logic [ADDRSIZE-1:0] w_addr_2_3,
  output logic                stage_done
);

  localparam int PMAX = 3;
  localparam int PIDX = (PE_LAT == 0) ? 0 : PE_LAT - 1;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    fcnt_q, fcnt_d;
  logic [2:0]    stage_q, stage_d;
  addr_pair_t    pipe_q [PMAX];
  addr_pair_t    pipe_d [PMAX];

  logic [CW-1:0] r01_q, r23_q, w01_q, w23_q;
  logic [CW-1:0] r01_d, r23_d, w01_d, w23_d;
  logic [CW-1:0] partner, w01_raw, w23_raw, w01_fin, w23_fin;
  route_e        m1_q, m1_d;
  logic          m0_q, m2_q, m3_q, done_q;
  logic          active_d, done_now, cnt_last;

  assign cnt_last = (cnt_q == CW'(DEPTH - 1));
  assign done_now = (state_q == ST_FLUSH) && (fcnt_q == 2'(PE_LAT));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    stage_d = stage_q;
    pipe_d  = pipe_q;
    if (ld_data) begin
      // Load start, restart and abort all share this path; an abort never reaches the done cycle.
      state_d = ST_LOAD;
      cnt_d   = '0;
      for (int i = 0; i < PMAX; i++) pipe_d[i] = '0;
    end else begin
      case (state_q)
        ST_LOAD: if (en) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_last) begin
            state_d = ST_RUN;
            stage_d = (int'(stage_num) >= NUMSTAGES) ? 3'(NUMSTAGES - 1) : stage_num;
          end
        end
        ST_RUN: if (en) begin
          for (int i = PMAX - 1; i > 0; i--) pipe_d[i] = pipe_q[i-1];
          pipe_d[0] = '{a01: r01_q, a23: r23_q};
          cnt_d     = cnt_q + CW'(1);
          if (cnt_last) begin
            state_d = ST_FLUSH;
            fcnt_d  = '0;
          end
        end
        ST_FLUSH: begin
          if (done_now) begin
            state_d = ST_IDLE;
          end else if (en) begin
            for (int i = PMAX - 1; i > 0; i--) pipe_d[i] = pipe_q[i-1];
            pipe_d[0] = '{a01: r01_q, a23: r23_q};
            fcnt_d    = fcnt_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  fft_addr_gen u_addr_gen (
    .stage   (stage_d),
    .cnt     (cnt_d),
    .raw_0_1 (w01_raw),
    .raw_2_3 (w23_raw),
    .partner (partner),
    .w_0_1   (w01_fin),
    .w_2_3   (w23_fin)
  );

  // Outputs are computed from next-state values so the registered outputs line up with the state.
  assign active_d = (state_d == ST_RUN) || (state_d == ST_FLUSH);
  assign r01_d    = (state_d == ST_RUN) ? cnt_d : '0;
  assign r23_d    = (state_d == ST_RUN) ? partner : '0;
  assign w01_raw  = (PE_LAT == 0) ? r01_d : pipe_d[PIDX].a01;
  assign w23_raw  = (PE_LAT == 0) ? r23_d : pipe_d[PIDX].a23;
  assign w01_d    = (state_d == ST_LOAD) ? cnt_d : (active_d ? w01_fin : '0);
  assign w23_d    = (state_d == ST_LOAD) ? cnt_d : (active_d ? w23_fin : '0);
  assign m1_d     = active_d ? route_for(stage_d) : ROUTE_STRAIGHT;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      stage_q <= '0;
      // NOTE: the delay pipe is small and must start clean, so it is reset like ordinary flops.
      for (int i = 0; i < PMAX; i++) pipe_q[i] <= '0;
      r01_q   <= '0;
      r23_q   <= '0;
      w01_q   <= '0;
      w23_q   <= '0;
      m0_q    <= 1'b0;
      m1_q    <= ROUTE_STRAIGHT;
      m2_q    <= 1'b0;
      m3_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      stage_q <= stage_d;
      pipe_q  <= pipe_d;
      r01_q   <= r01_d;
      r23_q   <= r23_d;
      w01_q   <= w01_d;
      w23_q   <= w23_d;
      m0_q    <= active_d;
      m1_q    <= m1_d;
      m2_q    <= (m1_d != ROUTE_STRAIGHT);
      m3_q    <= active_d && (int'(stage_d) == NUMSTAGES - 1);
      done_q  <= (state_d == ST_FLUSH) && (fcnt_d == 2'(PE_LAT));
    end
  end

  assign m0_s       = m0_q;
  assign m1_s       = m1_q;
  assign m2_s       = m2_q;
  assign m3_s       = m3_q;
  assign r_addr_0_1 = ADDRSIZE'(r01_q);
  assign r_addr_2_3 = ADDRSIZE'(r23_q);
  assign w_addr_0_1 = ADDRSIZE'(w01_q);
  assign w_addr_2_3 = ADDRSIZE'(w23_q);
  assign stage_done = done_q;

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Directed bench for fft_stage_ctrl (PE_LAT=1) with a write-address scoreboard.
module tb_fft_stage_ctrl;

`ifdef FFT_CTRL_BITREV_EN
  localparam bit BITREV = 1'b1;
`else
  localparam bit BITREV = 1'b0;
`endif

  logic       clk, rst_n, ld_data, en;
  logic [2:0] stage_num;
  logic       m0_s, m2_s, m3_s, stage_done;
  logic [1:0] m1_s;
  logic [7:0] r_addr_0_1, w_addr_0_1, r_addr_2_3, w_addr_2_3;

  int checks   = 0;
  int failures = 0;
  int q01[$];
  int q23[$];

  fft_stage_ctrl #(.ADDRSIZE(8), .PE_LAT(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_data    (ld_data),
    .en         (en),
    .stage_num  (stage_num),
    .m0_s       (m0_s),
    .m1_s       (m1_s),
    .m2_s       (m2_s),
    .m3_s       (m3_s),
    .r_addr_0_1 (r_addr_0_1),
    .w_addr_0_1 (w_addr_0_1),
    .r_addr_2_3 (r_addr_2_3),
    .w_addr_2_3 (w_addr_2_3),
    .stage_done (stage_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int partner_m(input int c, input int s);
    return (s < 6) ? (c ^ (1 << (5 - s))) : c;
  endfunction

  function automatic int wmap(input int v, input int s);
    int r;
    if (!(BITREV && s == 7)) return v;
    r = 0;
    for (int i = 0; i < 6; i++) if (v[i]) r |= (1 << (5 - i));
    return r;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_m0"}, int'(m0_s), 0);
    check({tag, "_m1"}, int'(m1_s), 0);
    check({tag, "_m2"}, int'(m2_s), 0);
    check({tag, "_m3"}, int'(m3_s), 0);
    check({tag, "_r01"}, int'(r_addr_0_1), 0);
    check({tag, "_r23"}, int'(r_addr_2_3), 0);
    check({tag, "_w01"}, int'(w_addr_0_1), 0);
    check({tag, "_w23"}, int'(w_addr_2_3), 0);
    check({tag, "_done"}, int'(stage_done), 0);
  endtask

  task automatic do_load();
    ld_data = 1'b1;
    en      = 1'b1;
    step();
    ld_data = 1'b0;
    for (int k = 0; k < 64; k++) begin
      check("load_w01", int'(w_addr_0_1), k);
      check("load_w23", int'(w_addr_2_3), k);
      if (k == 0 || k == 63) check("load_m0", int'(m0_s), 0);
      step();
    end
  endtask

  task automatic run_stage(input int stg, input int stall_at, input int abort_at, input bit ld_at_done);
    int e01, e23, cyc;
    int exp_m1;
    cyc    = 0;
    exp_m1 = (stg == 6) ? 1 : (stg == 7) ? 2 : 0;
    q01.delete();
    q23.delete();
    q01.push_back(0);
    q23.push_back(0);
    // stage_num changes mid-stage must not affect the running stage
    stage_num = 3'((stg + 3) % 8);
    check("run_m0", int'(m0_s), 1);
    check("run_m1", int'(m1_s), exp_m1);
    check("run_m2", int'(m2_s), (exp_m1 != 0) ? 1 : 0);
    check("run_m3", int'(m3_s), (stg == 7) ? 1 : 0);
    for (int c = 0; c < 64; c++) begin
      if (c == abort_at) begin
        ld_data = 1'b1;
        step();
        ld_data = 1'b0;
        check("abort_m0", int'(m0_s), 0);
        check("abort_w01", int'(w_addr_0_1), 0);
        check("abort_done", int'(stage_done), 0);
        for (int k = 1; k <= 8; k++) begin
          step();
          check("abort_reload_w01", int'(w_addr_0_1), k);
          check("abort_nodone", int'(stage_done), 0);
        end
        return;
      end
      e01 = q01.pop_front();
      e23 = q23.pop_front();
      check("run_r01", int'(r_addr_0_1), c);
      check("run_r23", int'(r_addr_2_3), partner_m(c, stg));
      check("run_w01", int'(w_addr_0_1), e01);
      check("run_w23", int'(w_addr_2_3), e23);
      check("run_done", int'(stage_done), 0);
      q01.push_back(wmap(c, stg));
      q23.push_back(wmap(partner_m(c, stg), stg));
      if (c == stall_at) begin
        en = 1'b0;
        repeat (3) begin
          step();
          cyc++;
          check("stall_r01", int'(r_addr_0_1), c);
          check("stall_w23", int'(w_addr_2_3), e23);
          check("stall_done", int'(stage_done), 0);
        end
        en = 1'b1;
      end
      step();
      cyc++;
    end
    e01 = q01.pop_front();
    e23 = q23.pop_front();
    check("flush_w01", int'(w_addr_0_1), e01);
    check("flush_w23", int'(w_addr_2_3), e23);
    check("flush_m0", int'(m0_s), 1);
    check("flush_done", int'(stage_done), 0);
    step();
    cyc++;
    check("done_pulse", int'(stage_done), 1);
    check("done_m3", int'(m3_s), (stg == 7) ? 1 : 0);
    check("stage_len", cyc, 65 + ((stall_at >= 0) ? 3 : 0));
    ld_data = ld_at_done;
    step();
    ld_data = 1'b0;
    check("after_done", int'(stage_done), 0);
    check("after_m0", int'(m0_s), 0);
    check("after_m3", int'(m3_s), 0);
    step();
    // LOAD advances the write counter, IDLE keeps it at 0
    check("after_state_w01", int'(w_addr_0_1), ld_at_done ? 1 : 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    ld_data   = 1'b0;
    en        = 1'b0;
    stage_num = 3'd0;
    step();
    step();
    rst_n = 1'b1;
    check_zero("reset");
    step();
    check_zero("idle");

    stage_num = 3'd0;
    do_load();
    run_stage(0, 10, -1, 1'b0);

    stage_num = 3'd7;
    do_load();
    run_stage(7, -1, -1, 1'b1);

    stage_num = 3'd6;
    do_load();
    run_stage(6, -1, 20, 1'b0);

    stage_num = 3'd1;
    do_load();
    repeat (5) step();
    check("pre_reset_r23", int'(r_addr_2_3), 5 ^ 16);
    rst_n = 1'b0;
    step();
    step();
    check_zero("midrun_reset");
    rst_n = 1'b1;
    step();
    check_zero("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
